// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the register file with pending scoreboard.
// Optional feature macro used by regfile_sb: REGFILE_BYPASS_EN.
package regfile_pkg;

   // Default geometry of the CPU register file.
   localparam int REGFILE_WIDTH = 32;
   localparam int REGFILE_NREGS = 32;
   localparam int REGFILE_AW    = $clog2(REGFILE_NREGS);

   // Register address at the default geometry.
   typedef logic [REGFILE_AW-1:0] reg_addr_t;

   // Hard-wired zero register: never stored, never written, never reserved.
   localparam reg_addr_t ZERO_REG = '0;

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// regfile_word: one WIDTH-bit storage register of the register file.
// Captures on the falling clock edge when enabled; cleared asynchronously by clr.
module regfile_word
   import regfile_pkg::*;
#(
   parameter int WIDTH = REGFILE_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   // Hold the stored value unless this word is the write target.
   always_comb begin
      word_d = en_i ? d_i : word_q;
   end

   // Falling-edge capture so a rising-edge consumer sees new data in the same cycle.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   // NOTE: each word has a real reset because clr must zero the whole file without a clock.
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q_o = word_q;

endmodule : regfile_word

// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x WIDTH register file with two combinational read ports,
// one falling-edge write port and a per-register pending scoreboard used by the
// hazard/stall unit. Register 0 is constant zero and is never pending.
// Optional feature: define REGFILE_BYPASS_EN for a combinational wdata->rdata
// write-through (busy forced low for a bypassed read). Default build has no
// such path.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH = REGFILE_WIDTH,
   parameter  int NREGS = REGFILE_NREGS,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_addr,
   output logic             busy_a,
   output logic             busy_b,
   output logic [AW:0]      n_pending
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   // ------------------------------------------------------------------
   // Storage: register 0 is a constant, registers 1..NREGS-1 are flops.
   // ------------------------------------------------------------------
   logic [NREGS-1:0][WIDTH-1:0] regs;

   assign regs[0] = '0;

   for (genvar g = 1; g < NREGS; g++) begin : g_word
      logic wr_en;

      assign wr_en = we && (waddr == AW'(g));

      regfile_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk  (clk),
         .clr  (clr),
         .en_i (wr_en),
         .d_i  (wdata),
         .q_o  (regs[g])
      );
   end

   // ------------------------------------------------------------------
   // Pending scoreboard: set by reserve, cleared by writeback.
   // ------------------------------------------------------------------
   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] pend_d;
   logic [AW:0]      n_pending_q;
   logic [AW:0]      n_pending_d;
   logic             wr_valid;
   logic             rsv_valid;

   assign wr_valid  = we && (waddr != ZERO_ADDR);
   assign rsv_valid = rsv_en && (rsv_addr != ZERO_ADDR);

   // Next pending vector: writeback retires, then a reserve on the same
   // register re-marks it, because a new producer issues as the old retires.
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      pend_d = pend_q;
      if (wr_valid) begin
         pend_d[waddr] = 1'b0;
      end
      if (rsv_valid) begin
         pend_d[rsv_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // Population count of the next pending vector, registered alongside it.
   always_comb begin
      n_pending_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         n_pending_d = n_pending_d + {{AW{1'b0}}, pend_d[i]};
      end
   end

   // Pending bits and count advance on the same falling edge as the data.
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         pend_q      <= '0;
         n_pending_q <= '0;
      end else begin
         pend_q      <= pend_d;
         n_pending_q <= n_pending_d;
      end
   end

   assign n_pending = n_pending_q;

   // ------------------------------------------------------------------
   // Read ports.
   // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
   logic byp_a;
   logic byp_b;

   assign byp_a = wr_valid && (waddr == raddr_a);
   assign byp_b = wr_valid && (waddr == raddr_b);

   // Write-through: an in-flight write to the read address is forwarded and
   // the register is no longer reported busy.
   assign rdata_a = byp_a ? wdata : regs[raddr_a];
   assign rdata_b = byp_b ? wdata : regs[raddr_b];
   assign busy_a  = pend_q[raddr_a] & ~byp_a;
   assign busy_b  = pend_q[raddr_b] & ~byp_b;
`else
   // Stored value only; a write appears after the falling edge that captures it.
   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
   assign busy_a  = pend_q[raddr_a];
   assign busy_b  = pend_q[raddr_b];
`endif

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb at default geometry.
// Inputs change just after a falling edge; outputs are sampled 1 ns after the
// falling edge that captures them, or mid-phase for asynchronous behaviour.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int W  = REGFILE_WIDTH;
   localparam int N  = REGFILE_NREGS;
   localparam int AW = REGFILE_AW;

   logic          clk;
   logic          clr;
   logic          we;
   reg_addr_t     waddr;
   logic [W-1:0]  wdata;
   reg_addr_t     raddr_a;
   reg_addr_t     raddr_b;
   logic [W-1:0]  rdata_a;
   logic [W-1:0]  rdata_b;
   logic          rsv_en;
   reg_addr_t     rsv_addr;
   logic          busy_a;
   logic          busy_b;
   logic [AW:0]   n_pending;

   int total = 0;
   int bad   = 0;

   regfile_sb #(
      .WIDTH (W),
      .NREGS (N)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr_a   (raddr_a),
      .raddr_b   (raddr_b),
      .rdata_a   (rdata_a),
      .rdata_b   (rdata_b),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .n_pending (n_pending)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Advance past the next capturing edge and settle.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      we       = 1'b0;
      rsv_en   = 1'b0;
      waddr    = '0;
      rsv_addr = '0;
      wdata    = '0;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      raddr_a = 5'd5;
      raddr_b = 5'd0;
      #2;
      total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata_a, 32'h0); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      total++; if (n_pending !== 6'd0) begin bad++; $display("FAIL reset_npend got=%0d exp=0", n_pending); end
      clr = 1'b0;
   endtask

   task automatic test_clr_midrun();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      rsv_en = 1'b1; rsv_addr = 5'd2;
      tick();
      idle();
      raddr_a = 5'd5; raddr_b = 5'd2;
      #1;
      total++; if (rdata_a !== 32'hDEADBEEF) begin bad++; $display("FAIL clr_pre_rdata got=%h exp=%h", rdata_a, 32'hDEADBEEF); end
      total++; if (n_pending !== 6'd1) begin bad++; $display("FAIL clr_pre_npend got=%0d exp=1", n_pending); end
      // Assert clr mid-phase; effect must be visible before any edge.
      clr = 1'b1;
      #1;
      total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL clr_rdata got=%h exp=0", rdata_a); end
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", busy_b); end
      total++; if (n_pending !== 6'd0) begin bad++; $display("FAIL clr_npend got=%0d exp=0", n_pending); end
      // Held clr ignores write and reserve across an edge.
      we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
      rsv_en = 1'b1; rsv_addr = 5'd5;
      tick();
      total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL clr_held_rdata got=%h exp=0", rdata_a); end
      total++; if (n_pending !== 6'd0) begin bad++; $display("FAIL clr_held_npend got=%0d exp=0", n_pending); end
      idle();
      clr = 1'b0;
   endtask

   task automatic test_zero_reg();
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      raddr_a = 5'd0;
      tick();
      total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL zero_rdata got=%h exp=0", rdata_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy_a); end
      total++; if (n_pending !== 6'd0) begin bad++; $display("FAIL zero_npend got=%0d exp=0", n_pending); end
      idle();
   endtask

   task automatic test_reserve_write();
      rsv_en = 1'b1; rsv_addr = 5'd3;
      tick();
      rsv_addr = 5'd7;
      tick();
      idle();
      raddr_a = 5'd3; raddr_b = 5'd7;
      #1;
      total++; if (n_pending !== 6'd2) begin bad++; $display("FAIL rsv_npend got=%0d exp=2", n_pending); end
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rsv_busy3 got=%b exp=1", busy_a); end
      total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL rsv_busy7 got=%b exp=1", busy_b); end
      we = 1'b1; waddr = 5'd3; wdata = 32'h12;
      tick();
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL wb_busy3 got=%b exp=0", busy_a); end
      total++; if (n_pending !== 6'd1) begin bad++; $display("FAIL wb_npend got=%0d exp=1", n_pending); end
      total++; if (rdata_a !== 32'h12) begin bad++; $display("FAIL wb_rdata3 got=%h exp=%h", rdata_a, 32'h12); end
      // Write to a register that is not pending leaves the count alone.
      waddr = 5'd10; wdata = 32'hCAFE0010; raddr_b = 5'd10;
      tick();
      total++; if (rdata_b !== 32'hCAFE0010) begin bad++; $display("FAIL np_rdata got=%h exp=%h", rdata_b, 32'hCAFE0010); end
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL np_busy got=%b exp=0", busy_b); end
      total++; if (n_pending !== 6'd1) begin bad++; $display("FAIL np_npend got=%0d exp=1", n_pending); end
      idle();
   endtask

   task automatic test_same_edge();
      we = 1'b1; waddr = 5'd9; wdata = 32'hAB;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      raddr_a = 5'd9;
      tick();
      total++; if (rdata_a !== 32'hAB) begin bad++; $display("FAIL same_rdata got=%h exp=%h", rdata_a, 32'hAB); end
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", busy_a); end
      total++; if (n_pending !== 6'd2) begin bad++; $display("FAIL same_npend got=%0d exp=2", n_pending); end
      idle();
   endtask

   task automatic test_back_to_back();
      clr_pulse();
      rsv_en = 1'b1;
      for (int i = 1; i < N; i++) begin
         rsv_addr = reg_addr_t'(i);
         tick();
      end
      total++; if (n_pending !== 6'd31) begin bad++; $display("FAIL all_npend got=%0d exp=31", n_pending); end
      rsv_addr = 5'd4;
      tick();
      total++; if (n_pending !== 6'd31) begin bad++; $display("FAIL rersv_npend got=%0d exp=31", n_pending); end
      rsv_en = 1'b0;
      we = 1'b1;
      for (int i = 1; i < N; i++) begin
         waddr = reg_addr_t'(i);
         wdata = 32'h1000 + i;
         tick();
      end
      idle();
      raddr_a = 5'd4; raddr_b = 5'd31;
      #1;
      total++; if (n_pending !== 6'd0) begin bad++; $display("FAIL wall_npend got=%0d exp=0", n_pending); end
      total++; if (rdata_a !== 32'h1004) begin bad++; $display("FAIL wall_r4 got=%h exp=%h", rdata_a, 32'h1004); end
      total++; if (rdata_b !== 32'h101F) begin bad++; $display("FAIL wall_r31 got=%h exp=%h", rdata_b, 32'h101F); end
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL wall_busy got=%b exp=0", busy_b); end
   endtask

   task automatic test_bypass();
      logic [W-1:0] exp_data;
      logic         exp_busy;
      // r6 holds 0x77 and is pending.
      we = 1'b1; waddr = 5'd6; wdata = 32'h77;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      tick();
      idle();
      raddr_a = 5'd6;
      // In-flight write, checked before the capturing edge.
      we = 1'b1; waddr = 5'd6; wdata = 32'h55;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_data = 32'h55;
      exp_busy = 1'b0;
`else
      exp_data = 32'h77;
      exp_busy = 1'b1;
`endif
      total++; if (rdata_a !== exp_data) begin bad++; $display("FAIL byp_rdata got=%h exp=%h", rdata_a, exp_data); end
      total++; if (busy_a !== exp_busy) begin bad++; $display("FAIL byp_busy got=%b exp=%b", busy_a, exp_busy); end
      tick();
      total++; if (rdata_a !== 32'h55) begin bad++; $display("FAIL byp_post_rdata got=%h exp=%h", rdata_a, 32'h55); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL byp_post_busy got=%b exp=0", busy_a); end
      idle();
   endtask

   initial begin
      clr     = 1'b1;
      raddr_a = '0;
      raddr_b = '0;
      idle();
      test_reset();
      test_clr_midrun();
      test_zero_reg();
      test_reserve_write();
      test_same_edge();
      test_back_to_back();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_sb
